// File: rtl/lcd_rect_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_rect_writer
// Purpose  : Rectangle-write sequencer in front of the LCD panel controller.
//            Accepts one window request (solid fill or streamed pixels). It
//            issues a window-set flag toggle, then one pixel-write flag toggle
//            per pixel, waiting out controller busy between transactions.
// Ports    : clk, resetn          - clock, async active-low reset
//            start/mode/x0..y1/color - request fields (sampled in IDLE)
//            abort                - terminate current request
//            px_data/px_valid/px_ready - streamed pixel handshake (mode 1)
//            eng_busy/done/err    - status to the MMIO register block
//            lcd_busy             - controller busy (incl. unconsumed toggle)
//            lcd_aflag/lcd_dflag  - window-set / pixel-write toggle flags
//            lcd_din, lcd_addrC, lcd_addrR - pixel value and window corners
// Revision : 1.0 - initial release
// ============================================================================
module lcd_rect_writer #(
  parameter int H_RES = 480,
  parameter int V_RES = 800
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  input  logic [15:0] y0,
  input  logic [15:0] y1,
  input  logic [15:0] color,
  input  logic        abort,
  input  logic [15:0] px_data,
  input  logic        px_valid,
  output logic        px_ready,
  output logic        eng_busy,
  output logic        done,
  output logic        err,
  input  logic        lcd_busy,
  output logic [7:0]  lcd_aflag,
  output logic [7:0]  lcd_dflag,
  output logic [15:0] lcd_din,
  output logic [31:0] lcd_addrC,
  output logic [31:0] lcd_addrR
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WIN      = 3'd1;
  localparam logic [2:0] S_WIN_WAIT = 3'd2;
  localparam logic [2:0] S_PIX      = 3'd3;
  localparam logic [2:0] S_PIX_WAIT = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;

  // 17-bit limits so a 16-bit coordinate compares without truncation
  localparam logic [16:0] H_LIM = 17'(H_RES);
  localparam logic [16:0] V_LIM = 17'(V_RES);

  logic [2:0]  state_q, state_d;
  logic        aflag_q, dflag_q;
  logic [15:0] din_q;
  logic [31:0] addrc_q, addrr_q;
  logic [15:0] col_q, row_q;
  logic        mode_q;
  logic [15:0] color_q;
  logic        last_q;
  logic        done_q, err_q;

  logic        req_ok;
  logic        accept;
  logic        issue_win;
  logic        issue_pix;
  logic        done_d;
  logic        err_d;
  logic        px_ready_c;
  logic        eng_busy_c;

  // Latched window corners: x0/y0 in the upper half, x1/y1 in the lower half
  logic [15:0] x0_q, x1_q, y1_q;
  assign x0_q = addrc_q[31:16];
  assign x1_q = addrc_q[15:0];
  assign y1_q = addrr_q[15:0];

  assign req_ok = (x0 <= x1) && (y0 <= y1) &&
                  ({1'b0, x1} < H_LIM) && ({1'b0, y1} < V_LIM);
  assign accept = (state_q == S_IDLE) && start && req_ok;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge resetn) begin : p_state
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = S_WIN;
      S_WIN:      if (abort) state_d = S_IDLE;
                  else if (!lcd_busy) state_d = S_WIN_WAIT;
      S_WIN_WAIT: if (abort) state_d = S_FLUSH;
                  else if (!lcd_busy) state_d = S_PIX;
      S_PIX:      if (abort) state_d = S_FLUSH;
                  else if (issue_pix) state_d = S_PIX_WAIT;
      S_PIX_WAIT: if (abort) state_d = S_FLUSH;
                  else if (!lcd_busy) state_d = last_q ? S_IDLE : S_PIX;
      S_FLUSH:    if (!lcd_busy) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin : p_out
    eng_busy_c = (state_q != S_IDLE);
    // Only a streaming request hands out px_ready; abort suppresses it
    px_ready_c = (state_q == S_PIX) && mode_q && !lcd_busy && !abort;
    issue_win  = (state_q == S_WIN) && !abort && !lcd_busy;
    issue_pix  = (state_q == S_PIX) && !abort &&
                 (mode_q ? (px_valid && px_ready_c) : !lcd_busy);
    done_d     = ((state_q == S_WIN) && abort) ||
                 ((state_q == S_PIX_WAIT) && !abort && !lcd_busy && last_q) ||
                 ((state_q == S_FLUSH) && !lcd_busy);
    err_d      = (state_q == S_IDLE) && start && !req_ok;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge resetn) begin : p_data
    if (!resetn) begin
      aflag_q <= 1'b0;
      dflag_q <= 1'b0;
      din_q   <= 16'h0;
      addrc_q <= 32'h0;
      addrr_q <= 32'h0;
      col_q   <= 16'h0;
      row_q   <= 16'h0;
      mode_q  <= 1'b0;
      color_q <= 16'h0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (accept) begin
        addrc_q <= {x0, x1};
        addrr_q <= {y0, y1};
        mode_q  <= mode;
        color_q <= color;
        col_q   <= x0;
        row_q   <= y0;
        last_q  <= 1'b0;
      end
      if (issue_win) aflag_q <= ~aflag_q;
      if (issue_pix) begin
        dflag_q <= ~dflag_q;
        din_q   <= mode_q ? px_data : color_q;
        // Raster advance; the pixel at the bottom-right corner is the last
        last_q  <= (col_q == x1_q) && (row_q == y1_q);
        if (col_q == x1_q) begin
          col_q <= x0_q;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end

  assign px_ready  = px_ready_c;
  assign eng_busy  = eng_busy_c;
  assign done      = done_q;
  assign err       = err_q;
  assign lcd_aflag = {7'b0, aflag_q};
  assign lcd_dflag = {7'b0, dflag_q};
  assign lcd_din   = din_q;
  assign lcd_addrC = addrc_q;
  assign lcd_addrR = addrr_q;

endmodule
`default_nettype wire
